// File: rtl/cdb_pkg.sv
// cdb_pkg: shared common-data-bus defaults and producer tag numbering
package cdb_pkg;

   localparam int CDB_DATA_WIDTH_DEF = 4;
   localparam int CDB_TAG_WIDTH_DEF  = 4;
   // producer i broadcasts with tag base+i; tag 0 stays free to mean "no producer"
   localparam int CDB_TAG_BASE_DEF   = 1;

   function automatic int tag_of(input int base, input int index);
      return base + index;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of one requester starting at ptr
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          found
);

   logic [N-1:0]   rot_req;
   logic [N-1:0]   rot_oh;
   logic [2*N-1:0] rot_back;

   // rotate so that the ptr position sits at bit 0, then isolate the lowest set bit
   assign rot_req  = N'({req, req} >> ptr);
   assign rot_oh   = rot_req & (~rot_req + N'(1));
   // undo the rotation; bits shifted past the top wrap back to the bottom
   assign rot_back = {{N{1'b0}}, rot_oh} << ptr;
   assign grant    = rot_back[N-1:0] | rot_back[2*N-1:N];
   assign found    = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin owner of the common data bus; optional counters via CDB_ARB_PERF_CNT_EN
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int DATA_WIDTH    = CDB_DATA_WIDTH_DEF,
   parameter int CDB_TAG_WIDTH = CDB_TAG_WIDTH_DEF,
   parameter int N_REQ         = 4,
   parameter int TAG_BASE      = CDB_TAG_BASE_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            accepted,
   input  logic                        stall,
   output logic                        cdb_valid,
   output logic [CDB_TAG_WIDTH-1:0]    cdb_tag,
   output logic [DATA_WIDTH-1:0]       cdb_data
`ifdef CDB_ARB_PERF_CNT_EN
   ,
   output logic [15:0]                 busy_cycles,
   output logic [15:0]                 stall_conflicts
`endif
);

   localparam int PW = $clog2(N_REQ);

   logic [N_REQ-1:0]      grant;
   logic                  found;
   logic                  fire;
   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         g_idx;
   logic [DATA_WIDTH-1:0] g_data;

   rr_priority_picker #(.N(N_REQ), .PW(PW)) u_picker (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .found (found)
   );

   // a grant only counts when the write port is free and we are out of reset
   assign fire     = found && !stall && !rst;
   assign accepted = fire ? grant : '0;

   // turn the one-hot grant into an index and select that producer's data
   always_comb begin
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) begin
            g_idx  = PW'(i);
            g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
   end

   // broadcast register and round-robin pointer; tag/data hold when nothing is granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         rr_ptr    <= '0;
      end else begin
         cdb_valid <= fire;
         if (fire) begin
            cdb_tag  <= CDB_TAG_WIDTH'(tag_of(TAG_BASE, int'(g_idx)));
            cdb_data <= g_data;
            rr_ptr   <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
         end
      end
   end

`ifdef CDB_ARB_PERF_CNT_EN
   // saturating counts of broadcast cycles and of requests blocked by stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cycles     <= '0;
         stall_conflicts <= '0;
      end else begin
         if (fire && busy_cycles != 16'hFFFF)
            busy_cycles <= busy_cycles + 16'd1;
         if (stall && |req && stall_conflicts != 16'hFFFF)
            stall_conflicts <= stall_conflicts + 16'd1;
      end
   end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between N_REQ result producers, such as ALU reservation stations and load units.
- Each cycle it grants at most one pending producer using round-robin priority, and returns a same-cycle accept pulse so the producer can release itself.
- The granted result is registered and broadcast on the CDB the next cycle, tagged with the producer's ID, to all CDB listeners.

Parameters:
- DATA_WIDTH, 4, bitwidth of a data word.
- CDB_TAG_WIDTH, 4, bitwidth of a CDB tag; must satisfy TAG_BASE+N_REQ-1 < 2^CDB_TAG_WIDTH.
- N_REQ, 4, number of producers; must be >= 2.
- TAG_BASE, 1, tag of producer 0. Producer i is tagged TAG_BASE+i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  req[i] = producer i has a result pending (its cdb_out_request).
- req_data  in  N_REQ*DATA_WIDTH  packed results; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- accepted  out  N_REQ  one-hot or zero, combinational; accepted[i] goes to producer i's cdb_out_accepted.
- stall  in  1  downstream (register-file write port) cannot take a broadcast this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  CDB_TAG_WIDTH  registered broadcast tag.
- cdb_data  out  DATA_WIDTH  registered broadcast data.

Behaviour:
- Reset (async, asserted or held): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0, perf counter=0.
- While rst is high, accepted=0 combinationally.
- rr_ptr (clog2(N_REQ) bits) names the highest-priority requester.
- Grant: the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - accepted[i]=1 only when a grant exists and stall=0.
  - accepted is combinational from req, rr_ptr and stall, and must not depend on cdb_* outputs.
- On a posedge with a grant g:
  - cdb_valid<=1, cdb_tag<=TAG_BASE+g, cdb_data<=req_data slice g.
  - rr_ptr<=(g+1) mod N_REQ. Wrap: g=N_REQ-1 gives rr_ptr=0.
- On a posedge with no grant (req all zero, or stall=1):
  - cdb_valid<=0; cdb_tag/cdb_data hold their previous values.
  - rr_ptr holds.
- Latency: exactly 1 cycle from accept to broadcast. Throughput: 1 result/cycle when stall=0.
- Stall:
  - No grant and no accept. Requests stay pending; producers keep req high.
  - A broadcast already registered still appears (it completes).
  - Priority is unchanged after stall drops.
- Fairness: a continuously requesting producer is granted within N_REQ grants.
- Simultaneous events:
  - A producer may drop req in the cycle after its accept and re-raise later; no special handling is needed.
  - A req rising in the same cycle as a grant to another producer competes from the next cycle.
- Reset mid-operation: a pending registered broadcast is discarded (cdb_valid=0 immediately, asynchronously). Producers that were accepted in the cycle before reset lose their result; this is acceptable because the whole core resets together.
- The block does not check that req_data is stable; it samples only at the granting edge.

Optional Feature:
- Macro CDB_ARB_PERF_CNT_EN.
- Defined:
  - Adds output port busy_cycles [15:0]: counts posedges where cdb_valid is written 1. Saturates at 16'hFFFF. Reset 0.
  - Adds output stall_conflicts [15:0]: counts posedges with stall=1 and req!=0. Saturates. Reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package cdb_pkg: CDB_TAG_WIDTH and DATA_WIDTH defaults, the TAG_BASE convention, and a function tag_of(index).
- Sub-module rr_priority_picker (parameter N): inputs req and ptr, outputs a one-hot grant and a found flag. It is purely combinational and reusable by future issue schedulers.
- The arbiter top holds rr_ptr, the output register and the optional counters.

Test Plan (N_REQ=4, DATA_WIDTH=4, TAG_BASE=1):
- Reset with req=4'b1111 and rst high for 2 cycles gives accepted=0, cdb_valid=0. After release, the first accept is accepted=4'b0001; the next cycle shows cdb_valid=1, cdb_tag=1.
- req=4'b1111 held with data 3,5,7,9 gives grants in order 0,1,2,3,0, tags 1,2,3,4,1 and data 3,5,7,9,3 on consecutive cycles.
- rr_ptr=3 with req=4'b1001 grants 3 (tag 4), then rr_ptr=0 and 0 is granted (tag 1). Checks wrap-around.
- req=4'b0100 with stall=1 for 3 cycles gives accepted=0 and cdb_valid=0 throughout. The cycle stall drops, accepted=4'b0100; the next cycle shows tag 3.
- Connect two alu_reservation_station instances computing 8-3 and 2-1: both results appear on the CDB (tag 1 data 5, then tag 2 data 1), and each station's reserved clears exactly after its accept.
- Assert rst asynchronously mid-cycle while cdb_valid=1: cdb_valid falls before the next edge. With CDB_ARB_PERF_CNT_EN defined, busy_cycles reads 0 after reset and 4 after 4 grants.
